math_booth_radix4_mult: RTL and testbench

Iterative radix-4 Booth multiplier: accepts one N-by-N operand pair per transaction and retires one Booth digit per clock into a 2N-bit product. Signed or unsigned operation is selected per transaction. Valid/ready handshakes on both sides let it sit in a datapath pipeline, as the area-optimised alternative to a full array multiplier in the common math library. Generalises the 3-bit Booth partial-product selector to a parametrised, sequenced multiply engine.

---
 rtl/math_booth_pkg.sv | 36 +++
 rtl/math_booth_radix4_pp.sv | 31 +++
 rtl/math_booth_radix4_mult.sv | 133 +++++++++++++
 tb/tb_math_booth_radix4_mult.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
// Contents:
//   booth_digit_t  - the recoded Booth digit (0, +A, +2A, -2A, -A)
//   booth_state_t  - the sequencer state (IDLE, CALC, DONE)
//   booth_decode   - maps a 3-bit multiplier window to its Booth digit
package math_booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } booth_state_t;

  // Window is {B[2k+1], B[2k], B[2k-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t dig;
    dig = ZERO;
    case (win)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/math_booth_radix4_pp.sv
// Combinational radix-4 Booth partial-product selector.
// Ports:
//   window_i  3-bit multiplier window {B[2k+1], B[2k], B[2k-1]}
//   mcand_i   multiplicand already extended to N+2 bits (signed view)
//   pp_o      N+3-bit signed partial product (0, +-A, +-2A)
module math_booth_radix4_pp
  import math_booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic        [2:0] window_i,
  input  logic        [N+1:0] mcand_i,
  output logic signed [N+2:0] pp_o
);

  // One extra sign bit so that 2A and -2A never overflow.
  logic signed [N+2:0] a3;
  assign a3 = {mcand_i[N+1], mcand_i};

  always_comb begin
    pp_o = '0;
    case (booth_decode(window_i))
      POS1:    pp_o = a3;
      POS2:    pp_o = a3 <<< 1;
      NEG1:    pp_o = -a3;
      NEG2:    pp_o = -(a3 <<< 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/math_booth_radix4_mult.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid / o_ready             operand handshake (accept in IDLE only)
//   i_signed                      1 = two's-complement operands, 0 = unsigned
//   i_multiplicand, i_multiplier  N-bit operands A and B
//   o_valid / i_ready             product handshake (held in DONE)
//   o_product                     2N-bit exact product, holds outside DONE
module math_booth_radix4_mult
  import math_booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [N-1:0]     i_multiplicand,
  input  logic [N-1:0]     i_multiplier,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*N-1:0]   o_product
);

  localparam int unsigned D     = N / 2 + 1;
  localparam int unsigned AW    = N + 2;
  localparam int unsigned BW    = N + 3;
  localparam int unsigned PW    = N + 3;
  localparam int unsigned ACCW  = 2 * N + 2;
  localparam int unsigned CNT_W = $clog2(D);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

  booth_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      a_q, a_d;
  logic [BW-1:0]      b_q, b_d;
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [2*N-1:0]     prod_q, prod_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic [2:0]         window;
  logic signed [PW-1:0] pp;
  logic [ACCW-1:0]    pp_ext;
  logic [ACCW-1:0]    pp_shift;

  // Select the current 3-bit window; B already carries the implicit 0 at bit 0.
  always_comb begin
    window = 3'b000;
    for (int unsigned k = 0; k < D; k++) begin
      if (cnt_q == CNT_W'(k)) window = b_q[2*k +: 3];
    end
  end

  math_booth_radix4_pp #(
    .N (N)
  ) u_pp (
    .window_i (window),
    .mcand_i  (a_q),
    .pp_o     (pp)
  );

  // Sign-extend the partial product and weight it by 4^k.
  assign pp_ext   = {{(ACCW - PW){pp[PW-1]}}, pp};
  assign pp_shift = pp_ext << {cnt_q, 1'b0};

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_signed ? {{2{i_multiplicand[N-1]}}, i_multiplicand}
                             : {2'b00, i_multiplicand};
          b_d     = i_signed ? {{2{i_multiplier[N-1]}}, i_multiplier, 1'b0}
                             : {2'b00, i_multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_shift;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          prod_d  = acc_d[2*N-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_product = prod_q;

endmodule

// File: tb/tb_math_booth_radix4_mult.sv
// Testbench for math_booth_radix4_mult: directed vectors at N=8 and N=16
// plus random operands checked against a plain A*B reference.
module tb_math_booth_radix4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, r8, sg8, vo8, rd8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        v16, r16, sg16, vo16, rd16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  math_booth_radix4_mult #(.N(8)) dut8 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (v8),
    .o_ready        (r8),
    .i_signed       (sg8),
    .i_multiplicand (a8),
    .i_multiplier   (b8),
    .o_valid        (vo8),
    .i_ready        (rd8),
    .o_product      (p8)
  );

  math_booth_radix4_mult #(.N(16)) dut16 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (v16),
    .o_ready        (r16),
    .i_signed       (sg16),
    .i_multiplicand (a16),
    .i_multiplier   (b16),
    .o_valid        (vo16),
    .i_ready        (rd16),
    .o_product      (p16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    logic [15:0] ea, eb;
    ea = sg ? {{8{a[7]}}, a} : {8'h00, a};
    eb = sg ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sg);
    logic [31:0] ea, eb;
    ea = sg ? {{16{a[15]}}, a} : {16'h0000, a};
    eb = sg ? {{16{b[15]}}, b} : {16'h0000, b};
    return ea * eb;
  endfunction

  // One complete transaction on the N=8 instance; lat = cycles from accept to o_valid (-1 on timeout).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                     input int rdy_dly, output logic [15:0] p, output int lat);
    int n;
    n = 0;
    rd8 = 1'b0;
    while (!r8 && n < 50) begin tick(); n++; end
    a8 = a; b8 = b; sg8 = sg; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
    lat = 0;
    while (!vo8 && lat < 50) begin tick(); lat++; end
    if (!vo8) lat = -1;
    repeat (rdy_dly) tick();
    p = p8;
    rd8 = 1'b1;
    tick();
    rd8 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                      input int rdy_dly, output logic [31:0] p, output int lat);
    int n;
    n = 0;
    rd16 = 1'b0;
    while (!r16 && n < 50) begin tick(); n++; end
    a16 = a; b16 = b; sg16 = sg; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
    lat = 0;
    while (!vo16 && lat < 50) begin tick(); lat++; end
    if (!vo16) lat = -1;
    repeat (rdy_dly) tick();
    p = p16;
    rd16 = 1'b1;
    tick();
    rd16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v8 = 1'b0; rd8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    v16 = 1'b0; rd16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) tick();
    rst = 1'b0;
    vec_cnt++; if (r8 !== 1'b1) begin err_cnt++; $display("FAIL reset_ready8: got %b want 1", r8); end
    vec_cnt++; if (vo8 !== 1'b0) begin err_cnt++; $display("FAIL reset_valid8: got %b want 0", vo8); end
    vec_cnt++; if (p8 !== 16'h0000) begin err_cnt++; $display("FAIL reset_product8: got %h want 0000", p8); end
    vec_cnt++; if (r16 !== 1'b1) begin err_cnt++; $display("FAIL reset_ready16: got %b want 1", r16); end
    vec_cnt++; if (vo16 !== 1'b0) begin err_cnt++; $display("FAIL reset_valid16: got %b want 0", vo16); end
    vec_cnt++; if (p16 !== 32'h0) begin err_cnt++; $display("FAIL reset_product16: got %h want 00000000", p16); end
  endtask

  task automatic test_signed_corner();
    logic [15:0] p; int lat;
    op8(8'h80, 8'h80, 1'b1, 0, p, lat);
    vec_cnt++; if (p !== 16'h4000) begin err_cnt++; $display("FAIL s_m128xm128: got %h want 4000", p); end
    vec_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL latency8: got %0d want 5", lat); end
  endtask

  task automatic test_all_ones();
    logic [15:0] p; int lat;
    op8(8'hFF, 8'hFF, 1'b0, 0, p, lat);
    vec_cnt++; if (p !== 16'hFE01) begin err_cnt++; $display("FAIL u_ffxff: got %h want fe01", p); end
    op8(8'hFF, 8'hFF, 1'b1, 0, p, lat);
    vec_cnt++; if (p !== 16'h0001) begin err_cnt++; $display("FAIL s_ffxff: got %h want 0001", p); end
  endtask

  task automatic test_small();
    logic [15:0] p; int lat;
    op8(8'hFF, 8'h01, 1'b1, 1, p, lat);
    vec_cnt++; if (p !== 16'hFFFF) begin err_cnt++; $display("FAIL s_m1x1: got %h want ffff", p); end
    op8(8'h00, 8'hA5, 1'b0, 2, p, lat);
    vec_cnt++; if (p !== 16'h0000) begin err_cnt++; $display("FAIL u_0xa5: got %h want 0000", p); end
  endtask

  task automatic test_backpressure();
    int n, lat;
    n = 0;
    rd8 = 1'b0;
    while (!r8 && n < 50) begin tick(); n++; end
    a8 = 8'h12; b8 = 8'h34; sg8 = 1'b0; v8 = 1'b1;
    tick();
    // i_valid stays high with the next operand pair; it must wait for IDLE.
    a8 = 8'h07; b8 = 8'h09;
    lat = 0;
    while (!vo8 && lat < 50) begin tick(); lat++; end
    vec_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL bp_latency: got %0d want 5", lat); end
    for (int i = 0; i < 10; i++) begin
      vec_cnt++; if (vo8 !== 1'b1 || p8 !== 16'h03A8 || r8 !== 1'b0) begin
        err_cnt++; $display("FAIL bp_hold cycle %0d: valid=%b product=%h ready=%b want 1/03a8/0", i, vo8, p8, r8);
      end
      tick();
    end
    rd8 = 1'b1;
    tick();
    rd8 = 1'b0;
    vec_cnt++; if (r8 !== 1'b1 || vo8 !== 1'b0) begin err_cnt++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", r8, vo8); end
    vec_cnt++; if (p8 !== 16'h03A8) begin err_cnt++; $display("FAIL bp_product_hold: got %h want 03a8", p8); end
    tick();
    v8 = 1'b0;
    vec_cnt++; if (r8 !== 1'b0) begin err_cnt++; $display("FAIL bp_accept: ready=%b want 0", r8); end
    lat = 0;
    while (!vo8 && lat < 50) begin tick(); lat++; end
    vec_cnt++; if (p8 !== 16'h003F || lat != 5) begin err_cnt++; $display("FAIL bp_second: product=%h lat=%0d want 003f/5", p8, lat); end
    rd8 = 1'b1;
    tick();
    rd8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; int n, lat; bit seen;
    n = 0;
    while (!r8 && n < 50) begin tick(); n++; end
    a8 = 8'h55; b8 = 8'h66; sg8 = 1'b0; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++; if (r8 !== 1'b1 || vo8 !== 1'b0 || p8 !== 16'h0000) begin
      err_cnt++; $display("FAIL midreset: ready=%b valid=%b product=%h want 1/0/0000", r8, vo8, p8);
    end
    seen = 1'b0;
    repeat (8) begin if (vo8) seen = 1'b1; tick(); end
    vec_cnt++; if (seen) begin err_cnt++; $display("FAIL midreset_no_valid: got valid pulse want none"); end
    op8(8'h03, 8'h05, 1'b0, 0, p, lat);
    vec_cnt++; if (p !== 16'h000F) begin err_cnt++; $display("FAIL after_reset_3x5: got %h want 000f", p); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [5] = '{8'h7F, 8'h80, 8'h7F, 8'hA5, 8'hFE};
    logic [7:0]  vb [5] = '{8'h80, 8'h80, 8'h7F, 8'h5A, 8'h03};
    logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ve [5] = '{16'hC080, 16'h4000, 16'h3F01, 16'h3A02, 16'hFFFA};
    int acc_cyc, prev_cyc, n, lat;
    prev_cyc = 0;
    rd8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!r8 && n < 50) begin tick(); n++; end
      a8 = va[i]; b8 = vb[i]; sg8 = vs[i]; v8 = 1'b1;
      tick();
      v8 = 1'b0;
      acc_cyc = cyc;
      if (i > 0) begin
        vec_cnt++; if (acc_cyc - prev_cyc != 7) begin err_cnt++; $display("FAIL b2b_period %0d: got %0d want 7", i, acc_cyc - prev_cyc); end
      end
      prev_cyc = acc_cyc;
      lat = 0;
      while (!vo8 && lat < 50) begin tick(); lat++; end
      vec_cnt++; if (p8 !== ve[i] || lat != 5) begin
        err_cnt++; $display("FAIL b2b_vec %0d: product=%h lat=%0d want %h/5", i, p8, lat, ve[i]);
      end
      tick();
    end
    rd8 = 1'b0;
  endtask

  task automatic test_random8();
    logic [7:0] a, b; logic sg; logic [15:0] p, e; int lat;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom); b = 8'($urandom); sg = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      op8(a, b, sg, int'($urandom_range(0, 3)), p, lat);
      e = ref8(a, b, sg);
      vec_cnt++; if (p !== e || lat != 5) begin
        err_cnt++; $display("FAIL rand8 %0d: a=%h b=%h s=%b product=%h lat=%0d want %h/5", i, a, b, sg, p, lat, e);
      end
    end
  endtask

  task automatic test_n16();
    logic [15:0] a, b; logic sg; logic [31:0] p, e; int lat;
    op16(16'h8000, 16'h8000, 1'b1, 0, p, lat);
    vec_cnt++; if (p !== 32'h4000_0000) begin err_cnt++; $display("FAIL s16_min_sq: got %h want 40000000", p); end
    vec_cnt++; if (lat != 9) begin err_cnt++; $display("FAIL latency16: got %0d want 9", lat); end
    op16(16'hFFFF, 16'hFFFF, 1'b0, 1, p, lat);
    vec_cnt++; if (p !== 32'hFFFE_0001) begin err_cnt++; $display("FAIL u16_ffff_sq: got %h want fffe0001", p); end
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); sg = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      op16(a, b, sg, int'($urandom_range(0, 3)), p, lat);
      e = ref16(a, b, sg);
      vec_cnt++; if (p !== e || lat != 9) begin
        err_cnt++; $display("FAIL rand16 %0d: a=%h b=%h s=%b product=%h lat=%0d want %h/9", i, a, b, sg, p, lat, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed_corner();
    test_all_ones();
    test_small();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_n16();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
